// File: rtl/block_draw_sequencer.sv
// block_draw_sequencer: drives the framebuffer write port to erase/draw the moving block or clear the screen.
module block_draw_sequencer #(
  parameter int BLOCK_W = 32,
  parameter int BLOCK_H = 16,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       clear,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  output logic       busy,
  output logic       done,
  output logic       plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour
);
  typedef enum logic [2:0] {IDLE, CLEAR, ERASE, DRAW, DONE} state_t;
  state_t state;
  logic [7:0] req_x, prev_x, dx, base_x, last_dx;
  logic [6:0] req_y, prev_y, dy, base_y, last_dy;
  logic [2:0] req_col;
  logic prev_valid, sweep, last;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  always_comb begin
    sweep = state inside {CLEAR, ERASE, DRAW};
    last_dx = state == CLEAR ? 8'(SCREEN_W - 1) : 8'(BLOCK_W - 1);
    last_dy = state == CLEAR ? 7'(SCREEN_H - 1) : 7'(BLOCK_H - 1);
    last = dx == last_dx && dy == last_dy;
    base_x = state == ERASE ? prev_x : state == DRAW ? req_x : 8'd0;
    base_y = state == ERASE ? prev_y : state == DRAW ? req_y : 7'd0;
    // Off-screen pixels still take their cycle; only the write enable is masked.
    sum_x = {1'b0, base_x} + {1'b0, dx};
    sum_y = {1'b0, base_y} + {1'b0, dy};
    plot = sweep && sum_x < 9'(SCREEN_W) && sum_y < 8'(SCREEN_H);
    vga_x = sweep ? sum_x[7:0] : 8'd0;
    vga_y = sweep ? sum_y[6:0] : 7'd0;
    vga_colour = state == DRAW ? req_col : sweep ? BG_COLOUR : 3'd0;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      prev_valid <= 1'b0;
      dx <= '0;
      dy <= '0;
      req_x <= '0;
      req_y <= '0;
      req_col <= '0;
      prev_x <= '0;
      prev_y <= '0;
    end else begin
      case (state)
        IDLE: begin
          dx <= '0;
          dy <= '0;
          if (clear) state <= CLEAR;
          else if (start) begin
            req_x <= x_in;
            req_y <= y_in;
            req_col <= colour_in;
            state <= prev_valid ? ERASE : DRAW;
          end
        end
        CLEAR, ERASE, DRAW: begin
          dx <= dx == last_dx ? 8'd0 : dx + 8'd1;
          dy <= last ? 7'd0 : dx == last_dx ? dy + 7'd1 : dy;
          if (last) begin
            state <= state == ERASE ? DRAW : DONE;
            if (state == DRAW) begin
              prev_x <= req_x;
              prev_y <= req_y;
              prev_valid <= 1'b1;
            end
            if (state == CLEAR) prev_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_block_draw_sequencer.sv
// tb_block_draw_sequencer: directed checks of redraw, clipping, clear, ignored requests and mid-sweep reset.
module tb_block_draw_sequencer;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, clear = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic busy, done, plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  int n_cmp = 0, n_err = 0;

  block_draw_sequencer dut (
    .clk(clk), .resetn(resetn), .start(start), .clear(clear),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .busy(busy), .done(done), .plot(plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " plot"}, 32'(plot), 0);
    chk({tag, " x"}, 32'(vga_x), 0);
    chk({tag, " y"}, 32'(vga_y), 0);
    chk({tag, " colour"}, 32'(vga_colour), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
  endtask

  // Leaves the bench at the negedge of the first pixel cycle.
  task automatic issue(input logic s, input logic c, input logic [7:0] x, input logic [6:0] y, input logic [2:0] col);
    @(negedge clk);
    start = s;
    clear = c;
    x_in = x;
    y_in = y;
    colour_in = col;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
  endtask

  // Checks every sweep cycle against an independent pixel model, then the done pulse and return to idle.
  task automatic sweep(input string tag, input bit er, input int px, input int py, input bit clr,
                       input int nx, input int ny, input int col, input int exp_plots, input bit pulse);
    int n, bad, plots, i, j, ex, ey, ec;
    bit in_er, ep;
    n = clr ? 19200 : (er ? 1024 : 512);
    bad = 0;
    plots = 0;
    for (int k = 1; k <= n; k++) begin
      i = k - 1;
      in_er = er && i < 512;
      j = (er && !in_er) ? i - 512 : i;
      ex = clr ? j % 160 : (in_er ? px : nx) + j % 32;
      ey = clr ? j / 160 : (in_er ? py : ny) + j / 32;
      ec = (clr || in_er) ? 0 : col;
      ep = ex < 160 && ey < 120;
      if (plot !== ep || vga_x !== 8'(ex) || vga_y !== 7'(ey) || vga_colour !== 3'(ec) || busy !== 1'b1 || done !== 1'b0)
        bad++;
      if (plot === 1'b1) plots++;
      if (pulse && k < n - 2) begin
        start = (k % 7 == 0);
        x_in = 8'(k);
        y_in = 7'(k);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " pixel errors"}, 32'(bad), 0);
    chk({tag, " plot count"}, 32'(plots), 32'(exp_plots));
    chk({tag, " done pulse"}, 32'(done), 1);
    chk({tag, " plot in done"}, 32'(plot), 0);
    @(negedge clk);
    chk({tag, " done width"}, 32'(done), 0);
    chk({tag, " busy after"}, 32'(busy), 0);
  endtask

  initial begin
    int idle_busy;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    resetn = 1'b1;
    issue(1, 0, 8'd0, 7'd104, 3'b010);
    sweep("first draw", 0, 0, 0, 0, 0, 104, 2, 512, 0);
    issue(1, 0, 8'd8, 7'd104, 3'b010);
    sweep("erase+draw", 1, 0, 104, 0, 8, 104, 2, 1024, 0);
    issue(1, 0, 8'd140, 7'd8, 3'b101);
    sweep("clipped", 1, 8, 104, 0, 140, 8, 5, 832, 0);
    issue(1, 1, 8'd50, 7'd50, 3'b111);
    sweep("clear", 0, 0, 0, 1, 0, 0, 0, 19200, 0);
    issue(1, 0, 8'd20, 7'd30, 3'b011);
    sweep("after clear", 0, 0, 0, 0, 20, 30, 3, 512, 0);
    issue(1, 0, 8'd60, 7'd40, 3'b110);
    sweep("busy pulses", 1, 20, 30, 0, 60, 40, 6, 1024, 1);
    idle_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) idle_busy++;
    end
    chk("no queued op", 32'(idle_busy), 0);
    issue(1, 0, 8'd10, 7'd10, 3'b001);
    repeat (99) @(negedge clk);
    chk("pre-reset x", 32'(vga_x), 63);
    chk("pre-reset y", 32'(vga_y), 43);
    chk("pre-reset busy", 32'(busy), 1);
    resetn = 1'b0;
    #1;
    chk_quiet("mid reset");
    @(negedge clk);
    resetn = 1'b1;
    issue(1, 0, 8'd10, 7'd10, 3'b001);
    sweep("post reset", 0, 0, 0, 0, 10, 10, 1, 512, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
